// File: rtl/clock_pkg.sv
// Shared definitions for the clock buzzer: FSM states, source codes and the
// BCD hour to chime-toggle-count decode.
package clock_pkg;

  // State encoding doubles as the one-hot src code.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CHIME = 2'b01,
    ALARM = 2'b10
  } state_t;

  localparam logic [1:0] SRC_NONE  = 2'b00;
  localparam logic [1:0] SRC_CHIME = 2'b01;
  localparam logic [1:0] SRC_ALARM = 2'b10;

  // Two toggles per hour struck, midnight strikes 24; invalid BCD gives 0.
  function automatic logic [5:0] hour_to_toggles(input logic [7:0] bcd);
    logic [3:0] tens;
    logic [3:0] units;
    logic [4:0] hour;
    tens  = bcd[7:4];
    units = bcd[3:0];
    if (units > 4'd9 || tens > 4'd2 || (tens == 4'd2 && units > 4'd3)) begin
      return 6'd0;
    end
    hour = 5'(tens) * 5'd10 + 5'(units);
    if (hour == 5'd0) begin
      return 6'd48;
    end
    return {hour, 1'b0};
  endfunction

endpackage

// File: rtl/chime_count.sv
// Combinational BCD hour to chime toggle count decoder.
module chime_count
  import clock_pkg::*;
(
  input  logic [7:0] bcd,
  output logic [5:0] count
);

  assign count = hour_to_toggles(bcd);

endmodule

// File: rtl/buzzer_sched.sv
// Buzzer scheduler: arbitrates the hourly chime and the alarm (with snooze)
// onto a single ring output.
module buzzer_sched
  import clock_pkg::*;
#(
  parameter int ALARM_LEN  = 120,
  parameter int SNOOZE_LEN = 300
) (
  input  logic       cp,
  input  logic       rst,
  input  logic [7:0] hours,
  input  logic [7:0] minte,
  input  logic [7:0] secd,
  input  logic       alarm_en,
  input  logic [7:0] alarm_hr,
  input  logic [7:0] alarm_min,
  input  logic       snooze,
  input  logic       stop,
  output logic       ring,
  output logic [1:0] src,
  output logic       snoozing
);

  // Toggle counter must hold both ALARM_LEN and the longest chime (48).
  localparam int TW = (ALARM_LEN > 63) ? $clog2(ALARM_LEN + 1) : 6;
  localparam logic [TW-1:0] ALARM_END = TW'(ALARM_LEN);
  localparam logic [8:0]    SNZ_LOAD  = 9'(SNOOZE_LEN);

  logic          chime_match, alarm_match;
  logic          chime_q, alarm_q, armed;
  logic          chime_evt, alarm_evt, snz_expire, alarm_req;
  logic [5:0]    hour_cnt;
  state_t        state, state_n;
  logic          ring_n, pend, pend_n, snoozing_n;
  logic [TW-1:0] tcnt, tcnt_n, tnext;
  logic [5:0]    clen, clen_n;
  logic [8:0]    scnt, scnt_n;

  chime_count u_chime_count (
    .bcd   (hours),
    .count (hour_cnt)
  );

  assign chime_match = (minte == 8'h59) && (secd == 8'h59);
  assign alarm_match = alarm_en && (hours == alarm_hr) && (minte == alarm_min) && (secd == 8'h00);

  // armed stays low for the first cycle after reset so a match already
  // present at release only primes the edge registers.
  assign chime_evt  = armed && chime_match && !chime_q && (hour_cnt != 6'd0);
  assign alarm_evt  = armed && alarm_match && !alarm_q;
  assign snz_expire = snoozing && (scnt <= 9'd1) && !stop && alarm_en;
  assign alarm_req  = alarm_evt || snz_expire;

  assign tnext = tcnt + TW'(1);

  assign src = (state == ALARM) ? SRC_ALARM :
               (state == CHIME) ? SRC_CHIME : SRC_NONE;

  // Edge-detect registers for the chime and alarm time matches.
  always_ff @(posedge cp or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      chime_q <= 1'b0;
      alarm_q <= 1'b0;
      armed   <= 1'b0;
    end else begin
      chime_q <= chime_match;
      alarm_q <= alarm_match;
      armed   <= 1'b1;
    end
  end

  // State register and datapath registers.
  always_ff @(posedge cp or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ring     <= 1'b0;
      tcnt     <= '0;
      clen     <= 6'd0;
      pend     <= 1'b0;
      scnt     <= 9'd0;
      snoozing <= 1'b0;
    end else begin
      state    <= state_n;
      ring     <= ring_n;
      tcnt     <= tcnt_n;
      clen     <= clen_n;
      pend     <= pend_n;
      scnt     <= scnt_n;
      snoozing <= snoozing_n;
    end
  end

  // Next-state, ring sequencing, pending chime and snooze countdown.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_n    = state;
    ring_n     = ring;
    tcnt_n     = tcnt;
    clen_n     = clen;
    pend_n     = pend;
    snoozing_n = snoozing;
    scnt_n     = (scnt != 9'd0) ? scnt - 9'd1 : 9'd0;

    if (snz_expire) begin
      snoozing_n = 1'b0;
    end
    if (stop || !alarm_en) begin
      snoozing_n = 1'b0;
      scnt_n     = 9'd0;
    end

    unique case (state)
      IDLE: begin
        ring_n = 1'b0;
        tcnt_n = '0;
        if (alarm_req) begin
          state_n = ALARM;
        end else if (chime_evt) begin
          state_n = CHIME;
          clen_n  = hour_cnt;
          pend_n  = 1'b0;
        end else if (pend) begin
          state_n = CHIME;
          pend_n  = 1'b0;
        end
      end
      CHIME: begin
        if (alarm_req) begin
          state_n = ALARM;
          ring_n  = 1'b0;
          tcnt_n  = '0;
        end else if (tnext == TW'(clen)) begin
          state_n = IDLE;
          ring_n  = 1'b0;
          tcnt_n  = '0;
        end else begin
          ring_n = !ring;
          tcnt_n = tnext;
        end
      end
      ALARM: begin
        if (chime_evt) begin
          pend_n = 1'b1;
          clen_n = hour_cnt;
        end
        if (stop || snooze || tnext == ALARM_END) begin
          state_n = IDLE;
          ring_n  = 1'b0;
          tcnt_n  = '0;
          if (snooze && !stop && alarm_en) begin
            snoozing_n = 1'b1;
            scnt_n     = SNZ_LOAD;
          end
        end else begin
          ring_n = !ring;
          tcnt_n = tnext;
        end
      end
      default: begin
        state_n = IDLE;
        ring_n  = 1'b0;
        tcnt_n  = '0;
      end
    endcase
  end

endmodule

// File: doc/buzzer_sched.md
BUZZER_SCHED -- requirements
Module: buzzer_sched

Interface
REQ-001 SHALL have parameter ALARM_LEN, default 120: number of ring toggles for one alarm burst.
REQ-002 SHALL have parameter SNOOZE_LEN, default 300: cp cycles from snooze to alarm re-fire.
REQ-003 SHALL have port cp, input, 1: single clock, rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port hours, input, 8: current hour, BCD 00-23.
REQ-006 SHALL have port minte, input, 8: current minute, BCD 00-59.
REQ-007 SHALL have port secd, input, 8: current second, BCD 00-59.
REQ-008 SHALL have port alarm_en, input, 1: alarm armed.
REQ-009 SHALL have port alarm_hr, input, 8: alarm hour, BCD.
REQ-010 SHALL have port alarm_min, input, 8: alarm minute, BCD.
REQ-011 SHALL have port snooze, input, 1: single-cycle snooze pulse.
REQ-012 SHALL have port stop, input, 1: single-cycle stop pulse.
REQ-013 SHALL have port ring, output, 1: buzzer drive.
REQ-014 SHALL have port src, output, 2: active source (00 none, 01 chime, 10 alarm).
REQ-015 SHALL have port snoozing, output, 1: snooze countdown active.

Function
REQ-016 SHALL detect a chime event on the rising edge of (minte==59 && secd==59); a level held for multiple cycles SHALL produce one event.
REQ-017 SHALL detect an alarm event on the rising edge of (alarm_en && hours==alarm_hr && minte==alarm_min && secd==00).
REQ-018 SHALL latch the chime toggle count at the event as 2*h for h = 1..23 and 48 for h = 00; invalid BCD SHALL give 0, and the event SHALL be discarded.
REQ-019 SHALL implement the states IDLE, CHIME and ALARM; the one-hot encoding of src SHALL mirror the state.
REQ-020 IDLE->ALARM SHALL occur on an alarm event or snooze expiry; otherwise IDLE->CHIME SHALL occur on a chime event or a pending chime.
REQ-021 SHALL toggle ring once per cp while in CHIME or ALARM, beginning the cycle after entry.
REQ-022 CHIME->IDLE SHALL occur after the latched count of toggles; ring SHALL be 0 on exit.
REQ-023 ALARM->IDLE SHALL occur after ALARM_LEN toggles, or on stop, or on snooze; ring SHALL be forced to 0 in the exit cycle.
REQ-024 Alarm SHALL preempt CHIME: the remaining chime SHALL be abandoned, and no pending chime SHALL be set.
REQ-025 A chime event during ALARM SHALL set a one-deep pending flag, serviced on return to IDLE; a second chime event SHALL overwrite the latched count.
REQ-026 Snooze in ALARM SHALL load the snooze counter with SNOOZE_LEN and set snoozing; snooze outside ALARM SHALL be ignored.
REQ-027 When snooze expires, snoozing SHALL clear and an alarm request SHALL be raised, which coincides with a fresh alarm event as a single start.
REQ-028 Stop SHALL clear snoozing and the snooze counter in any state; stop in CHIME SHALL be ignored.
REQ-029 Deasserting alarm_en SHALL clear the snooze state but SHALL NOT abort an ALARM in progress.
REQ-030 Simultaneous snooze and stop SHALL be treated as stop.
REQ-031 The snooze counter SHALL be 9 bits, SHALL saturate at 0, and SHALL keep running during CHIME.

Reset
REQ-032 rst low SHALL immediately force ring=0, src=00, snoozing=0, state IDLE, all counters and the pending flag clear, and the edge-detect registers to 0, including mid-burst.
REQ-033 Time matches present at reset release SHALL NOT fire, because the edge-detect registers SHALL load the current match value on the first cycle.

Structure
REQ-034 The BCD hour-to-toggle-count decode, the state encoding and the src codes SHALL live in a shared package, clock_pkg.
REQ-035 The hour decode SHALL be a sub-module, chime_count, that is combinational, takes 8-bit BCD in and gives a 6-bit count out.

Verification
REQ-036 Hour 03, time to 03:59:59 -> src=01, 6 ring toggles, then ring=0 and src=00.
REQ-037 Hour 00 at xx:59:59 -> 48 toggles; hours=8'h2A -> no chime.
REQ-038 Alarm 07:30, time 07:30:00 -> src=10 with 120 toggles; snooze at toggle 10 -> ring=0, snoozing=1, and re-fire after 300 cycles.
REQ-039 Alarm running when 07:59:59 is reached -> chime pending; after the alarm ends, a 14-toggle chime runs.
REQ-040 rst pulsed low mid-chime -> ring=0 and src=00 asynchronously; with the match held at release, no re-fire occurs.
REQ-041 Stop during snooze countdown -> snoozing=0 and no re-fire after 300 cycles.
